// File: rtl/arm_pkg.sv
// arm_pkg: shared ALU encodings, NZCV bit positions and the control bundle type
package arm_pkg;
    localparam logic [3:0] EXE_CMD_NOP = 4'b0000;
    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic s;
        logic b;
    } ctrl_t;

    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic en);
        return en ? c : '0;
    endfunction
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: ID-side inputs, EX-side outputs and pipeline controls of the ID/EX register
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              freeze, flush, cond_ok;
    logic              id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_s, id_b, id_imm;
    logic [DATA_W-1:0] id_pc, id_val_rn, id_val_rm;
    logic [3:0]        id_exe_cmd, id_dest, id_src1, id_src2, id_status;
    logic [11:0]       id_shift_operand;
    logic [23:0]       id_simm24;
    logic              ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_s, ex_b, ex_imm;
    logic [DATA_W-1:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [3:0]        ex_exe_cmd, ex_dest, ex_src1, ex_src2, ex_status;
    logic [11:0]       ex_shift_operand;
    logic [23:0]       ex_simm24;
    logic [CNT_W-1:0]  squash_cnt;

    modport master (
        output freeze, flush, cond_ok, id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_s, id_b,
               id_imm, id_pc, id_val_rn, id_val_rm, id_exe_cmd, id_dest, id_src1, id_src2,
               id_status, id_shift_operand, id_simm24,
        input  ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_s, ex_b, ex_imm, ex_pc,
               ex_val_rn, ex_val_rm, ex_exe_cmd, ex_dest, ex_src1, ex_src2, ex_status,
               ex_shift_operand, ex_simm24, squash_cnt
    );

    modport slave (
        input  freeze, flush, cond_ok, id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_s, id_b,
               id_imm, id_pc, id_val_rn, id_val_rm, id_exe_cmd, id_dest, id_src1, id_src2,
               id_status, id_shift_operand, id_simm24,
        output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_s, ex_b, ex_imm, ex_pc,
               ex_val_rn, ex_val_rm, ex_exe_cmd, ex_dest, ex_src1, ex_src2, ex_status,
               ex_shift_operand, ex_simm24, squash_cnt
    );
endinterface

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: pipeline register with reset > flush > freeze > load priority
module pipe_field_reg #(
    parameter int W         = 8,
    parameter bit FLUSH_CLR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         freeze_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;

    always_comb q_d = flush_i ? (FLUSH_CLR ? '0 : d_i) : freeze_i ? q_q : d_i;

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register that squashes side effects of condition-failed instructions
module id_ex_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_reg_if.slave bus
);
    localparam int DW = 3 * DATA_W + 57;

    logic [DW-1:0]    data_q;
    logic [5:0]       ctrl_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            id_ctrl;
    logic             exec, load;

    assign id_ctrl = '{bus.id_wb_en, bus.id_mem_r_en, bus.id_mem_w_en, bus.id_s, bus.id_b};
    assign exec    = bus.id_valid & bus.cond_ok;
    assign load    = ~bus.flush & ~bus.freeze;

    pipe_field_reg #(.W(DW), .FLUSH_CLR(1'b0)) u_data (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (bus.flush),
        .freeze_i (bus.freeze),
        .d_i      ({bus.id_pc, bus.id_val_rn, bus.id_val_rm, bus.id_exe_cmd, bus.id_imm,
                    bus.id_shift_operand, bus.id_simm24, bus.id_dest, bus.id_src1,
                    bus.id_src2, bus.id_status}),
        .q_o      (data_q)
    );

    pipe_field_reg #(.W(6), .FLUSH_CLR(1'b1)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (bus.flush),
        .freeze_i (bus.freeze),
        .d_i      ({bus.id_valid, gate_ctrl(id_ctrl, exec)}),
        .q_o      (ctrl_q)
    );

    assign {bus.ex_pc, bus.ex_val_rn, bus.ex_val_rm, bus.ex_exe_cmd, bus.ex_imm,
            bus.ex_shift_operand, bus.ex_simm24, bus.ex_dest, bus.ex_src1,
            bus.ex_src2, bus.ex_status} = data_q;
    assign {bus.ex_valid, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en,
            bus.ex_s, bus.ex_b} = ctrl_q;

    // Counts only instructions actually leaving ID; saturates instead of wrapping
    always_comb cnt_d = (load && bus.id_valid && !bus.cond_ok && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.squash_cnt = cnt_q;
endmodule
